// File: rtl/mips_pkg.sv
// Shared constants and types for the 4-stage MIPS integer core.
package mips_pkg;

    // Primary opcodes (instr[31:26])
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ORI   = 6'h0D;

    // R-type function codes (instr[5:0])
    localparam logic [5:0] F_ADD = 6'h20;
    localparam logic [5:0] F_SUB = 6'h22;
    localparam logic [5:0] F_AND = 6'h24;
    localparam logic [5:0] F_OR  = 6'h25;
    localparam logic [5:0] F_NOR = 6'h27;
    localparam logic [5:0] F_SLT = 6'h2A;
    localparam logic [5:0] F_SLL = 6'h00;

    // ALU operation selected in ID and carried to EX
    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_AND  = 4'd2,
        ALU_OR   = 4'd3,
        ALU_NOR  = 4'd4,
        ALU_SLT  = 4'd5,
        ALU_SLL  = 4'd6,
        ALU_ZERO = 4'd7
    } alu_op_t;

    // Encoding of the canonical NOP (sll $0,$0,0); also loaded into IF/ID bubbles
    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

endpackage

// File: rtl/alu_param.sv
// Combinational integer ALU of configurable width; arithmetic wraps.
module alu_param
    import mips_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [4:0]        sh,
    input  alu_op_t           op,
    output logic [DATA_W-1:0] y
);

    // Select the operation result; unknown/NOP operations yield zero
    always_comb begin
        y = '0;
        case (op)
            ALU_ADD:  y = a + b;
            ALU_SUB:  y = a - b;
            ALU_AND:  y = a & b;
            ALU_OR:   y = a | b;
            ALU_NOR:  y = ~(a | b);
            ALU_SLT:  y = ($signed(a) < $signed(b)) ? {{(DATA_W-1){1'b0}}, 1'b1} : '0;
            ALU_SLL:  y = b << sh;
            ALU_ZERO: y = '0;
            default:  y = '0;
        endcase
    end

endmodule

// File: rtl/mips_pipe_core.sv
// 4-stage (IF, ID, EX, WB) MIPS integer core with EX/WB->EX forwarding,
// write-through register file, global stall and saturating retire counter.
module mips_pipe_core
    import mips_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int PC_W   = 8,
    parameter int NREG   = 32,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic [PC_W-1:0]   imem_addr,
    input  logic [31:0]       imem_data,
    input  logic              imem_ready,
    input  logic              stall,
    output logic [DATA_W-1:0] salida,
    output logic              wb_valid,
    output logic [4:0]        wb_reg,
    output logic [CNT_W-1:0]  retired
);

    localparam logic [5:0] NREG_L = 6'(NREG);

    // Architectural and pipeline state
    logic [PC_W-1:0]   pc_r;
    logic [31:0]       ifid_instr_r;
    logic              ifid_valid_r;
    logic              idex_valid_r;
    alu_op_t           idex_alu_r;
    logic [4:0]        idex_rs_r;
    logic [4:0]        idex_rt_r;
    logic [4:0]        idex_dest_r;
    logic              idex_wr_r;
    logic              idex_use_imm_r;
    logic [4:0]        idex_sh_r;
    logic [DATA_W-1:0] idex_a_r;
    logic [DATA_W-1:0] idex_b_r;
    logic [DATA_W-1:0] idex_imm_r;
    logic              exwb_valid_r;
    logic              exwb_wr_r;
    logic [4:0]        exwb_dest_r;
    logic [DATA_W-1:0] exwb_result_r;
    logic [CNT_W-1:0]  retired_r;
    logic [DATA_W-1:0] rf_r [32];

    // Decode and datapath signals
    logic [4:0]        dec_rs_s;
    logic [4:0]        dec_rt_s;
    alu_op_t           dec_alu_s;
    logic [4:0]        dec_dest_s;
    logic              dec_wr_raw_s;
    logic              dec_wr_s;
    logic              dec_use_imm_s;
    logic [DATA_W-1:0] dec_imm_s;
    logic [DATA_W-1:0] rs_val_s;
    logic [DATA_W-1:0] rt_val_s;
    logic              wb_we_s;
    logic              fwd_a_s;
    logic              fwd_b_s;
    logic [DATA_W-1:0] ex_a_s;
    logic [DATA_W-1:0] ex_b_s;
    logic [DATA_W-1:0] ex_y_s;

    assign dec_rs_s = ifid_instr_r[25:21];
    assign dec_rt_s = ifid_instr_r[20:16];

    // Decode opcode/func into ALU op, destination, write enable and immediate
    always_comb begin
        dec_alu_s     = ALU_ZERO;
        dec_dest_s    = 5'd0;
        dec_wr_raw_s  = 1'b0;
        dec_use_imm_s = 1'b0;
        dec_imm_s     = DATA_W'($signed(ifid_instr_r[15:0]));
        case (ifid_instr_r[31:26])
            OP_RTYPE: begin
                dec_dest_s   = ifid_instr_r[15:11];
                dec_wr_raw_s = 1'b1;
                case (ifid_instr_r[5:0])
                    F_ADD:   dec_alu_s = ALU_ADD;
                    F_SUB:   dec_alu_s = ALU_SUB;
                    F_AND:   dec_alu_s = ALU_AND;
                    F_OR:    dec_alu_s = ALU_OR;
                    F_NOR:   dec_alu_s = ALU_NOR;
                    F_SLT:   dec_alu_s = ALU_SLT;
                    F_SLL:   dec_alu_s = ALU_SLL;
                    default: begin
                        dec_alu_s    = ALU_ZERO;
                        dec_wr_raw_s = 1'b0;
                    end
                endcase
            end
            OP_ADDI: begin
                dec_alu_s     = ALU_ADD;
                dec_dest_s    = dec_rt_s;
                dec_wr_raw_s  = 1'b1;
                dec_use_imm_s = 1'b1;
            end
            OP_ORI: begin
                dec_alu_s     = ALU_OR;
                dec_dest_s    = dec_rt_s;
                dec_wr_raw_s  = 1'b1;
                dec_use_imm_s = 1'b1;
                dec_imm_s     = DATA_W'(ifid_instr_r[15:0]);
            end
            default: begin
                dec_alu_s    = ALU_ZERO;
                dec_wr_raw_s = 1'b0;
            end
        endcase
    end

    // $0 and unimplemented registers are never written, so they never forward either
    assign dec_wr_s = dec_wr_raw_s && (dec_dest_s != 5'd0) && ({1'b0, dec_dest_s} < NREG_L);
    assign wb_we_s  = exwb_valid_r && exwb_wr_r && !stall;

    // Register file read with write-through of the same-cycle WB write
    always_comb begin
        rs_val_s = '0;
        rt_val_s = '0;
        if (dec_rs_s == 5'd0 || {1'b0, dec_rs_s} >= NREG_L) begin
            rs_val_s = '0;
        end else if (wb_we_s && exwb_dest_r == dec_rs_s) begin
            rs_val_s = exwb_result_r;
        end else begin
            rs_val_s = rf_r[dec_rs_s];
        end
        if (dec_rt_s == 5'd0 || {1'b0, dec_rt_s} >= NREG_L) begin
            rt_val_s = '0;
        end else if (wb_we_s && exwb_dest_r == dec_rt_s) begin
            rt_val_s = exwb_result_r;
        end else begin
            rt_val_s = rf_r[dec_rt_s];
        end
    end

    // EX operand selection: forward the EX/WB result over stale ID/EX values
    always_comb begin
        fwd_a_s = exwb_valid_r && exwb_wr_r && (exwb_dest_r != 5'd0) && (exwb_dest_r == idex_rs_r);
        fwd_b_s = exwb_valid_r && exwb_wr_r && (exwb_dest_r != 5'd0) && (exwb_dest_r == idex_rt_r);
        ex_a_s  = fwd_a_s ? exwb_result_r : idex_a_r;
        if (idex_use_imm_r) begin
            ex_b_s = idex_imm_r;
        end else if (fwd_b_s) begin
            ex_b_s = exwb_result_r;
        end else begin
            ex_b_s = idex_b_r;
        end
    end

    alu_param #(.DATA_W(DATA_W)) u_alu (
        .a  (ex_a_s),
        .b  (ex_b_s),
        .sh (idex_sh_r),
        .op (idex_alu_r),
        .y  (ex_y_s)
    );

    // Advance PC and the three pipeline registers unless stalled
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_r           <= '0;
            ifid_instr_r   <= NOP_INSTR;
            ifid_valid_r   <= 1'b0;
            idex_valid_r   <= 1'b0;
            idex_alu_r     <= ALU_ZERO;
            idex_rs_r      <= 5'd0;
            idex_rt_r      <= 5'd0;
            idex_dest_r    <= 5'd0;
            idex_wr_r      <= 1'b0;
            idex_use_imm_r <= 1'b0;
            idex_sh_r      <= 5'd0;
            idex_a_r       <= '0;
            idex_b_r       <= '0;
            idex_imm_r     <= '0;
            exwb_valid_r   <= 1'b0;
            exwb_wr_r      <= 1'b0;
            exwb_dest_r    <= 5'd0;
            exwb_result_r  <= '0;
        end else if (!stall) begin
            if (imem_ready) begin
                pc_r         <= pc_r + {{(PC_W-1){1'b0}}, 1'b1};
                ifid_instr_r <= imem_data;
                ifid_valid_r <= 1'b1;
            end else begin
                ifid_instr_r <= NOP_INSTR;
                ifid_valid_r <= 1'b0;
            end
            idex_valid_r   <= ifid_valid_r;
            idex_alu_r     <= dec_alu_s;
            idex_rs_r      <= dec_rs_s;
            idex_rt_r      <= dec_rt_s;
            idex_dest_r    <= dec_dest_s;
            idex_wr_r      <= ifid_valid_r && dec_wr_s;
            idex_use_imm_r <= dec_use_imm_s;
            idex_sh_r      <= ifid_instr_r[10:6];
            idex_a_r       <= rs_val_s;
            idex_b_r       <= rt_val_s;
            idex_imm_r     <= dec_imm_s;
            exwb_valid_r   <= idex_valid_r;
            exwb_wr_r      <= idex_valid_r && idex_wr_r;
            exwb_dest_r    <= idex_valid_r ? idex_dest_r : 5'd0;
            exwb_result_r  <= idex_valid_r ? ex_y_s : '0;
        end
    end

    // Register file write from WB, once per instruction as it leaves the stage
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) begin
                rf_r[i] <= '0;
            end
        end else if (wb_we_s) begin
            rf_r[exwb_dest_r] <= exwb_result_r;
        end
    end

    // Count valid instructions leaving WB, saturating at all-ones
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            retired_r <= '0;
        end else if (!stall && exwb_valid_r && (retired_r != {CNT_W{1'b1}})) begin
            retired_r <= retired_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    assign imem_addr = pc_r;
    assign salida    = exwb_result_r;
    assign wb_valid  = exwb_valid_r && exwb_wr_r;
    assign wb_reg    = exwb_dest_r;
    assign retired   = retired_r;

endmodule
